// File: rtl/tx_frame_arbiter.sv
// Frame-level round-robin arbiter sharing one byte-wide transmit path between two sources.
// Forwards the granted port with one cycle of latency, enforcing IFG, MAX_LEN and a grant timeout.
module tx_frame_arbiter #(
  parameter int IFG           = 12,
  parameter int MAX_LEN       = 1518,
  parameter int GRANT_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  input  logic [7:0] rxd0,
  input  logic [7:0] rxd1,
  input  logic       rx_dv0,
  input  logic       rx_dv1,
  output logic [7:0] txd,
  output logic       tx_en,
  output logic       busy,
  output logic       err_timeout,
  output logic       err_overlen
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int TMO_W = $clog2(GRANT_TIMEOUT + 1);
  localparam int GAP_W = $clog2(IFG + 1);

  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(GRANT_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IFG - 1);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    XFER,
    DRAIN,
    GAP
  } state_e;

  state_e           state_q;
  logic             sel_q;
  logic             last_q;
  logic             gnt0_q;
  logic             gnt1_q;
  logic [7:0]       txd_q;
  logic             tx_en_q;
  logic             err_timeout_q;
  logic             err_overlen_q;
  logic [LEN_W-1:0] len_q;
  logic [TMO_W-1:0] tmo_q;
  logic [GAP_W-1:0] gap_q;

  // Only the selected port is ever looked at; the other port's inputs are dead.
  logic       req_s;
  logic       rx_dv_s;
  logic [7:0] rxd_s;
  logic       pick1;

  assign req_s   = sel_q ? req1   : req0;
  assign rx_dv_s = sel_q ? rx_dv1 : rx_dv0;
  assign rxd_s   = sel_q ? rxd1   : rxd0;

  // A lone requester wins; with both requesting, the port not served last wins.
  assign pick1 = req1 & (~req0 | ~last_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sel_q         <= 1'b0;
      last_q        <= 1'b1;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      txd_q         <= 8'h00;
      tx_en_q       <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overlen_q <= 1'b0;
      len_q         <= '0;
      tmo_q         <= '0;
      gap_q         <= '0;
    end else begin
      // NOTE: every register here uses <= so all branches see the pre-edge values of state and counters.
      err_timeout_q <= 1'b0;
      err_overlen_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_en_q <= 1'b0;
          if (req0 || req1) begin
            sel_q   <= pick1;
            last_q  <= pick1;
            gnt0_q  <= ~pick1;
            gnt1_q  <= pick1;
            tmo_q   <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (rx_dv_s) begin
            tx_en_q <= 1'b1;
            txd_q   <= rxd_s;
            len_q   <= LEN_W'(1);
            state_q <= XFER;
          end else if (!req_s) begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            state_q <= IDLE;
          end else if (tmo_q == TMO_LAST) begin
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            err_timeout_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        XFER: begin
          txd_q <= rxd_s;
          if (!rx_dv_s) begin
            tx_en_q <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            gap_q   <= GAP_LOAD;
            state_q <= GAP;
          end else if (len_q == LEN_MAX) begin
            // The byte that would exceed MAX_LEN is dropped; the rest of the burst is drained.
            tx_en_q       <= 1'b0;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            err_overlen_q <= 1'b1;
            state_q       <= DRAIN;
          end else begin
            tx_en_q <= 1'b1;
            len_q   <= len_q + LEN_W'(1);
          end
        end
        DRAIN: begin
          tx_en_q <= 1'b0;
          if (!rx_dv_s) begin
            gap_q   <= GAP_LOAD;
            state_q <= GAP;
          end
        end
        GAP: begin
          tx_en_q <= 1'b0;
          if (gap_q == '0) begin
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        default: begin
          tx_en_q <= 1'b0;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign txd         = txd_q;
  assign tx_en       = tx_en_q;
  assign busy        = (state_q != IDLE);
  assign err_timeout = err_timeout_q;
  assign err_overlen = err_overlen_q;

endmodule

// File: doc/tx_frame_arbiter.md
# tx_frame_arbiter

Two-port, frame-level round-robin arbiter that shares the single byte-wide transmit datapath (txd/tx_en) between two frame sources. Each source requests with req, receives a registered grant, then streams one frame as a contiguous rx_dv burst; the arbiter forwards it with one cycle of latency. The arbiter enforces a minimum inter-frame gap and a maximum frame length, and revokes grants that are never used. It sits between the frame sources and the existing byte-pipeline stage.

## Interface
- IFG, 12: tx_en-low cycles counted in the GAP state after every forwarded frame; must be ≥1.
- MAX_LEN, 1518: maximum bytes forwarded per frame; must be ≥1.
- GRANT_TIMEOUT, 16: cycles a grant may stay unused before revocation; must be ≥1.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0, req1  in  1  frame request per port; held until the frame starts.
- gnt0, gnt1  out  1  registered grant; at most one high.
- rxd0, rxd1  in  8  per-port data.
- rx_dv0, rx_dv1  in  1  per-port data valid; one contiguous burst per frame.
- txd  out  8  forwarded data.
- tx_en  out  1  forwarded valid.
- busy  out  1  high whenever state ≠ IDLE.
- err_timeout  out  1  one-cycle pulse on grant revocation.
- err_overlen  out  1  one-cycle pulse on frame truncation.

## Operation
- Reset: gnt0=gnt1=0, txd=0, tx_en=0, busy=0, err_*=0, state=IDLE, last=1 (so port 0 wins first), all counters 0. Reset mid-frame aborts the frame immediately; there is no drain.
- States: IDLE, GRANT, XFER, DRAIN, GAP. sel denotes the granted port.
- IDLE: if exactly one req is high, grant that port. If both are high, grant the port ≠ last. Set sel and last, set gnt_sel=1, go to GRANT.
- GRANT: wait for rx_dv_sel.
  - rx_dv_sel=1: forward the byte, len=1, go to XFER.
  - req_sel=0 with rx_dv_sel=0: withdrawal; gnt=0, go to IDLE, no error.
  - GRANT_TIMEOUT consecutive GRANT cycles with rx_dv_sel=0: gnt=0, err_timeout=1, go to IDLE.
- XFER: each cycle, tx_en<=rx_dv_sel and txd<=rxd_sel.
  - rx_dv_sel=0: end of frame; gnt=0, load the gap counter with IFG−1, go to GAP.
  - rx_dv_sel=1 with len==MAX_LEN: truncate. That byte is not forwarded (tx_en<=0). gnt=0, err_overlen=1, go to DRAIN.
  - rx_dv_sel=1 with len<MAX_LEN: len+1.
- DRAIN: tx_en=0. When rx_dv_sel=0, load the gap counter and go to GAP.
- GAP: tx_en=0. Decrement each cycle; at 0 go to IDLE. Requests are ignored in GAP.
- Outside GRANT/XFER, tx_en is 0 and txd holds its last value. The ungranted port's rx_dv/rxd are always ignored.
- len is $clog2(MAX_LEN+1) bits and saturates. The timeout counter is $clog2(GRANT_TIMEOUT+1) bits. Neither counter wraps.

## Timing
- Grant latency: req sampled high in IDLE at cycle k → gnt high in cycle k+1.
- Data latency: rx_dv_sel/rxd_sel in cycle t → tx_en/txd in cycle t+1, identical to the downstream pipeline stage.
- gnt falls in the cycle after rx_dv_sel is first sampled low. Sources must not re-assert rx_dv after gnt falls.
- Back-to-back frames, with the source asserting rx_dv in the first gnt cycle: tx_en is low for exactly IFG+2 cycles between frames.
- Timeout: gnt high for GRANT_TIMEOUT cycles; gnt low and the err_timeout pulse appear in the same following cycle.
- Simultaneous req0 and req1 in IDLE always alternate. A single persistent requester is re-granted after every GAP.
- Both rx_dv inputs high: only sel is observed.

## Test plan
- Single frame: req0, then 5 bytes 0x11..0x15 on port 0 → gnt0 one cycle after req0; tx_en high 5 cycles carrying 0x11..0x15, each one cycle after input; gnt0 drops; busy low after the IFG cycles of GAP.
- Round robin: req0 and req1 held, 3-byte frames each, IFG=4 → grant order port0, port1, port0; tx_en low for 6 cycles between frames; no port-1 data in port-0 frames.
- Timeout: req1 high, rx_dv1 never asserted, GRANT_TIMEOUT=16 → gnt1 high for 16 cycles, then gnt1=0 and a one-cycle err_timeout; busy returns to 0; the next grant goes to port 0 if both request.
- Overlength: MAX_LEN=8, port 0 sends 12 bytes → exactly 8 bytes forwarded; err_overlen pulses on the cycle tx_en drops; state holds in DRAIN until rx_dv0 falls, then GAP.
- Reset mid-frame: rst asserted during byte 3 of a 10-byte frame → next cycle gnt0=0, tx_en=0, busy=0. After release with both requests high, port 0 is granted first.
- Withdrawal and ignore: req1 dropped in GRANT before rx_dv1 → IDLE with no error. rx_dv0 toggling while port 1 is granted → never appears on txd/tx_en.
